pix_burst_scheduler: RTL and testbench

Sequences pixel-frame traffic between the HDMI capture write path and the DSI output read path over one shared memory command port. It arbitrates burst requests from the capture FIFO (drain) and the DSI fetch FIFO (fill), generates burst addresses inside two ping-pong frame buffers, and swaps buffers on frame boundaries. It sits between the capture/fetch FIFOs and the AXI master that drives the pixel memory slave.

---
 rtl/pix_sched_pkg.sv | 29 ++
 rtl/pix_burst_scheduler_if.sv | 21 ++
 rtl/fb_pingpong_ctrl.sv | 46 ++++
 rtl/pix_burst_scheduler.sv | 163 ++++++++++++++++
 tb/tb_pix_burst_scheduler.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pix_sched_pkg.sv
// Shared types and helpers for the pixel burst scheduler.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pix_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_t;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Command latched at grant time and held until the slave accepts it
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
  } cmd_t;

  function automatic logic [31:0] burst_bytes(input int unsigned beats);
    return 32'(beats * BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/pix_burst_scheduler_if.sv
// Burst command channel between the scheduler and the AXI master.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid holds until cmd_ready; cmd_done closes each burst.
interface pix_burst_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cmd_done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready, cmd_done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready, cmd_done
  );
endinterface

// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame buffer selection: writer/reader buffers, last complete frame, drop pulse.
// Latency: 1 cycle from an applied frame-start strobe to updated selects / frame_drop.
// Backpressure: none; strobes are applied by the caller only when their direction is idle.
module fb_pingpong_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_start,
  input  logic rd_start,
  input  logic wr_complete,
  output logic wr_buf_sel,
  output logic rd_buf_sel,
  output logic frame_valid,
  output logic frame_drop
);

  logic last_complete;
  logic frame_done;
  logic last_next;
  logic rd_next;

  // Write side resolves first so a simultaneous reader start picks up the fresh frame,
  // then the writer is pointed away from whatever the reader will be using.
  assign frame_done = wr_start && wr_complete;
  assign last_next  = frame_done ? wr_buf_sel : last_complete;
  assign rd_next    = rd_start ? last_next : rd_buf_sel;

  // Buffer ownership and frame status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_buf_sel    <= 1'b0;
      rd_buf_sel    <= 1'b1;
      last_complete <= 1'b0;
      frame_valid   <= 1'b0;
      frame_drop    <= 1'b0;
    end else begin
      rd_buf_sel    <= rd_next;
      last_complete <= last_next;
      frame_drop    <= wr_start && !wr_complete;
      if (frame_done) begin
        wr_buf_sel  <= ~rd_next;
        frame_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pix_burst_scheduler.sv
// Arbitrates capture-drain writes and DSI-fill reads onto one burst command port.
// Latency: grant 1 cycle after eligibility; next grant 2 cycles after cmd_done.
// Backpressure: cmd_valid/addr held until cmd_ready; one burst in flight until cmd_done.
module pix_burst_scheduler
  import pix_sched_pkg::*;
#(
  parameter logic [31:0] FB0_BASE    = 32'h0000_0000,
  parameter logic [31:0] FB1_BASE    = 32'h0012_C000,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned LVL_W       = 10,
  parameter int unsigned WR_URGENT   = 768
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [LVL_W-1:0] wr_level,
  input  logic             wr_frame_start,
  input  logic [LVL_W-1:0] rd_space,
  input  logic             rd_frame_start,
  pix_burst_scheduler_if.master cmd,
  output logic             wr_buf_sel,
  output logic             rd_buf_sel,
  output logic             frame_valid,
  output logic             frame_drop
);

  localparam logic [31:0] FRAME_BYTES = 32'(FRAME_WORDS * BYTES_PER_WORD);
  localparam logic [31:0] BURST_BYTES = burst_bytes(BURST_LEN);
  localparam logic [31:0] LAST_START  = FRAME_BYTES - BURST_BYTES;

  sched_state_t state;
  grant_t       last_grant;
  cmd_t         cmd_q;
  logic         cmd_valid_q;
  logic [31:0]  wr_off;
  logic [31:0]  rd_off;
  logic         wr_fs_pend;
  logic         rd_fs_pend;

  logic         wr_busy;
  logic         rd_busy;
  logic         wr_fs_apply;
  logic         rd_fs_apply;
  logic         wr_complete;
  logic         wr_elig;
  logic         rd_elig;
  logic         wr_urgent;
  logic         gnt_wr;
  logic         grant_go;
  logic [31:0]  gnt_addr;

  // Offsets stop at the frame end instead of wrapping into the next buffer
  function automatic logic [31:0] step_off(input logic [31:0] off);
    return (off >= LAST_START) ? FRAME_BYTES : off + BURST_BYTES;
  endfunction

  function automatic logic [31:0] buf_base(input logic sel);
    return sel ? FB1_BASE : FB0_BASE;
  endfunction

  assign wr_busy     = (state != ST_IDLE) && cmd_q.write;
  assign rd_busy     = (state != ST_IDLE) && !cmd_q.write;
  // A frame start touching the direction with a burst in flight waits until that burst closes
  assign wr_fs_apply = (wr_frame_start || wr_fs_pend) && !wr_busy;
  assign rd_fs_apply = (rd_frame_start || rd_fs_pend) && !rd_busy;
  assign wr_complete = (wr_off == FRAME_BYTES);

  assign wr_elig   = (32'(wr_level) >= 32'(BURST_LEN)) && (wr_off < FRAME_BYTES);
  assign rd_elig   = frame_valid && (32'(rd_space) >= 32'(BURST_LEN)) && (rd_off < FRAME_BYTES);
  assign wr_urgent = (32'(wr_level) >= 32'(WR_URGENT));

  // Grant selection: urgent write wins, otherwise alternate, lone requester always wins
  always_comb begin
    gnt_wr = 1'b0;
    if (wr_elig && wr_urgent) begin
      gnt_wr = 1'b1;
    end else if (wr_elig && rd_elig) begin
      gnt_wr = (last_grant == GNT_RD);
    end else begin
      gnt_wr = wr_elig;
    end
  end

  // Offsets and buffer selects move in a cycle with an applied frame start, so skip
  // arbitration for that one cycle rather than latch a stale address.
  assign grant_go = enable && (wr_elig || rd_elig) && !wr_fs_apply && !rd_fs_apply;
  assign gnt_addr = gnt_wr ? (buf_base(wr_buf_sel) + wr_off) : (buf_base(rd_buf_sel) + rd_off);

  // Command FSM with registered command outputs and burst offsets
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= GNT_RD;
      cmd_valid_q <= 1'b0;
      cmd_q.write <= 1'b0;
      cmd_q.addr  <= FB0_BASE;
      wr_off      <= '0;
      rd_off      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_go) begin
            cmd_valid_q <= 1'b1;
            cmd_q.write <= gnt_wr;
            cmd_q.addr  <= gnt_addr;
            last_grant  <= gnt_wr ? GNT_WR : GNT_RD;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state       <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (cmd.cmd_done) begin
            if (cmd_q.write) wr_off <= step_off(wr_off);
            else             rd_off <= step_off(rd_off);
            state <= ST_IDLE;
          end
        end
        default: begin
          cmd_valid_q <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
      // Never collides with the increment above: apply requires that direction idle
      if (wr_fs_apply) wr_off <= '0;
      if (rd_fs_apply) rd_off <= '0;
    end
  end

  // Frame-start pulses seen while their direction is busy are remembered until it idles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_fs_pend <= 1'b0;
      rd_fs_pend <= 1'b0;
    end else begin
      wr_fs_pend <= wr_busy ? (wr_fs_pend || wr_frame_start) : 1'b0;
      rd_fs_pend <= rd_busy ? (rd_fs_pend || rd_frame_start) : 1'b0;
    end
  end

  fb_pingpong_ctrl u_fb (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_start    (wr_fs_apply),
    .rd_start    (rd_fs_apply),
    .wr_complete (wr_complete),
    .wr_buf_sel  (wr_buf_sel),
    .rd_buf_sel  (rd_buf_sel),
    .frame_valid (frame_valid),
    .frame_drop  (frame_drop)
  );

  assign cmd.cmd_valid = cmd_valid_q;
  assign cmd.cmd_write = cmd_q.write;
  assign cmd.cmd_addr  = cmd_q.addr;
  assign cmd.cmd_len   = 8'(BURST_LEN - 1);

endmodule

// File: tb/tb_pix_burst_scheduler.sv
// Directed bench for pix_burst_scheduler: 64-word frames, 16-beat bursts, FB1 at 0x100.
// Latency: n/a.
// Backpressure: bench acts as the command slave (ready/done).
module tb_pix_burst_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [9:0] wr_level;
  logic       wr_frame_start;
  logic [9:0] rd_space;
  logic       rd_frame_start;
  logic       wr_buf_sel;
  logic       rd_buf_sel;
  logic       frame_valid;
  logic       frame_drop;

  pix_burst_scheduler_if cmd_if();

  pix_burst_scheduler #(
    .FB0_BASE    (32'h0000_0000),
    .FB1_BASE    (32'h0000_0100),
    .FRAME_WORDS (64),
    .BURST_LEN   (16),
    .LVL_W       (10),
    .WR_URGENT   (768)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .wr_level       (wr_level),
    .wr_frame_start (wr_frame_start),
    .rd_space       (rd_space),
    .rd_frame_start (rd_frame_start),
    .cmd            (cmd_if),
    .wr_buf_sel     (wr_buf_sel),
    .rd_buf_sel     (rd_buf_sel),
    .frame_valid    (frame_valid),
    .frame_drop     (frame_drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // One burst per row: inputs, expected command, plus per-row corner-case knobs
  typedef struct {
    logic [9:0]  wr_level;
    logic [9:0]  rd_space;
    logic        exp_w;
    logic [31:0] exp_a;
    int          gap;       // expected negedges from row start to cmd_valid, -1 = don't care
    int          rdy_dly;   // cycles cmd_ready is held low while cmd_valid is up
    logic        rd_pulse;  // pulse rd_frame_start while waiting for cmd_done
    logic        en_off;    // drop enable right after the command is accepted
  } vec_t;

  vec_t vec [18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(output int waited, output bit ok);
    waited = 0;
    ok     = 1'b0;
    while (!ok && waited < 40) begin
      if (cmd_if.cmd_valid === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
  endtask

  task automatic expect_idle(input int cycles, input string nm);
    int hits;
    hits = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (cmd_if.cmd_valid !== 1'b0) hits++;
    end
    check(nm, 32'(hits), 32'd0);
  endtask

  task automatic run_row(input int i);
    vec_t v;
    int   waited;
    bit   ok;
    int   unstable;
    v = vec[i];
    wr_level = v.wr_level;
    rd_space = v.rd_space;
    wait_valid(waited, ok);
    check($sformatf("row%0d_valid", i), 32'(ok), 32'd1);
    if (!ok) return;
    if (v.gap >= 0) check($sformatf("row%0d_gap", i), 32'(waited), 32'(v.gap));
    check($sformatf("row%0d_write", i), 32'(cmd_if.cmd_write), 32'(v.exp_w));
    check($sformatf("row%0d_addr", i), cmd_if.cmd_addr, v.exp_a);
    unstable = 0;
    repeat (v.rdy_dly) begin
      @(negedge clk);
      if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_addr !== v.exp_a || cmd_if.cmd_write !== v.exp_w)
        unstable++;
    end
    if (v.rdy_dly > 0) check($sformatf("row%0d_hold", i), 32'(unstable), 32'd0);
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
    if (v.en_off) enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rd_frame_start = v.rd_pulse && (k == 0);
    end
    cmd_if.cmd_done = 1'b1;
    @(negedge clk);
    cmd_if.cmd_done = 1'b0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_row(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int  waited;
    bit  ok;

    rst_n            = 1'b0;
    enable           = 1'b1;
    wr_level         = '0;
    rd_space         = '0;
    wr_frame_start   = 1'b0;
    rd_frame_start   = 1'b0;
    cmd_if.cmd_ready = 1'b0;
    cmd_if.cmd_done  = 1'b0;

    //          wr_lvl   rd_spc  w     addr          gap rdy pulse en_off
    vec[0]  = '{10'd16,  10'd0,  1'b1, 32'h0000_0000, -1, 0, 1'b0, 1'b0};
    vec[1]  = '{10'd16,  10'd0,  1'b1, 32'h0000_0040,  1, 0, 1'b0, 1'b0};
    vec[2]  = '{10'd16,  10'd0,  1'b1, 32'h0000_0080,  1, 0, 1'b0, 1'b0};
    vec[3]  = '{10'd16,  10'd0,  1'b1, 32'h0000_00C0,  1, 0, 1'b0, 1'b0};
    vec[4]  = '{10'd20,  10'd20, 1'b0, 32'h0000_0100, -1, 0, 1'b0, 1'b0};
    vec[5]  = '{10'd20,  10'd20, 1'b1, 32'h0000_0000,  1, 0, 1'b0, 1'b0};
    vec[6]  = '{10'd20,  10'd20, 1'b0, 32'h0000_0140,  1, 0, 1'b0, 1'b0};
    vec[7]  = '{10'd20,  10'd20, 1'b1, 32'h0000_0040,  1, 0, 1'b0, 1'b0};
    vec[8]  = '{10'd800, 10'd20, 1'b1, 32'h0000_0000, -1, 0, 1'b0, 1'b0};
    vec[9]  = '{10'd800, 10'd20, 1'b1, 32'h0000_0040,  1, 0, 1'b0, 1'b0};
    vec[10] = '{10'd800, 10'd20, 1'b1, 32'h0000_0080,  1, 0, 1'b0, 1'b0};
    vec[11] = '{10'd800, 10'd20, 1'b1, 32'h0000_00C0,  1, 0, 1'b0, 1'b0};
    vec[12] = '{10'd800, 10'd20, 1'b0, 32'h0000_0180,  1, 0, 1'b0, 1'b0};
    vec[13] = '{10'd0,   10'd20, 1'b0, 32'h0000_0000, -1, 0, 1'b1, 1'b0};
    vec[14] = '{10'd0,   10'd20, 1'b0, 32'h0000_0000, -1, 0, 1'b0, 1'b0};
    vec[15] = '{10'd16,  10'd0,  1'b1, 32'h0000_0100, -1, 10, 1'b0, 1'b1};
    vec[16] = '{10'd16,  10'd0,  1'b1, 32'h0000_0140, -1, 0, 1'b0, 1'b0};
    vec[17] = '{10'd16,  10'd0,  1'b1, 32'h0000_0000, -1, 0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_cmd_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("rst_cmd_write", 32'(cmd_if.cmd_write), 32'd0);
    check("rst_cmd_addr", cmd_if.cmd_addr, 32'h0);
    check("rst_cmd_len", 32'(cmd_if.cmd_len), 32'd15);
    check("rst_wr_buf", 32'(wr_buf_sel), 32'd0);
    check("rst_rd_buf", 32'(rd_buf_sel), 32'd1);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_frame_drop", 32'(frame_drop), 32'd0);

    // Write-only frame: valid one cycle after eligibility, four bursts, then saturate
    wr_level = 10'd16;
    @(negedge clk);
    check("first_latency", 32'(cmd_if.cmd_valid), 32'd1);
    run_rows(0, 3);
    expect_idle(20, "saturated_no_cmd");
    wr_level       = 10'd0;
    wr_frame_start = 1'b1;
    @(negedge clk);
    wr_frame_start = 1'b0;
    check("frame1_valid", 32'(frame_valid), 32'd1);
    check("frame1_wr_buf", 32'(wr_buf_sel), 32'd0);
    check("frame1_rd_buf", 32'(rd_buf_sel), 32'd1);
    check("frame1_no_drop", 32'(frame_drop), 32'd0);

    // Round-robin after a write grant: R, W, R, W
    run_rows(4, 7);

    // Drop after two of four write bursts
    wr_level       = 10'd0;
    rd_space       = 10'd0;
    wr_frame_start = 1'b1;
    @(negedge clk);
    wr_frame_start = 1'b0;
    check("drop_pulse", 32'(frame_drop), 32'd1);
    check("drop_frame_valid", 32'(frame_valid), 32'd1);
    check("drop_wr_buf", 32'(wr_buf_sel), 32'd0);
    @(negedge clk);
    check("drop_width", 32'(frame_drop), 32'd0);

    // Urgent writes take four grants in a row from offset 0, then the read resumes
    run_rows(8, 12);

    // Simultaneous frame starts: reader takes frame in buffer 0, writer moves to buffer 1
    wr_level       = 10'd0;
    rd_space       = 10'd0;
    wr_frame_start = 1'b1;
    rd_frame_start = 1'b1;
    @(negedge clk);
    wr_frame_start = 1'b0;
    rd_frame_start = 1'b0;
    check("simul_wr_buf", 32'(wr_buf_sel), 32'd1);
    check("simul_rd_buf", 32'(rd_buf_sel), 32'd0);
    check("simul_frame_valid", 32'(frame_valid), 32'd1);
    check("simul_no_drop", 32'(frame_drop), 32'd0);

    // Pending read frame start, stalled handshake, enable dropped mid-burst
    run_rows(13, 15);
    expect_idle(20, "enable_off_no_cmd");
    enable = 1'b1;
    run_rows(16, 16);

    // Reset during WAIT_DONE of write burst at 0x180
    wait_valid(waited, ok);
    check("rstmid_valid", 32'(ok), 32'd1);
    check("rstmid_addr", cmd_if.cmd_addr, 32'h0000_0180);
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_cmd_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("rstmid_cmd_addr", cmd_if.cmd_addr, 32'h0);
    check("rstmid_wr_buf", 32'(wr_buf_sel), 32'd0);
    check("rstmid_rd_buf", 32'(rd_buf_sel), 32'd1);
    check("rstmid_frame_valid", 32'(frame_valid), 32'd0);
    wr_level = 10'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmd_if.cmd_done = 1'b1;
    @(negedge clk);
    cmd_if.cmd_done = 1'b0;
    run_rows(17, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
